kv_lookup_responder: RTL and testbench

- Responder end of the key-request interface that eth_encap drives (in_key/in_flag/in_valid/in_ready out, out_valid/out_flag back).
- Holds a direct-mapped on-chip key table indexed by an XOR-folded hash of the key.
- Services lookup, insert and delete requests one at a time and returns a 4-bit result flag.
- Sits in the clk156 domain opposite eth_encap and replaces the external DB for board bring-up and closed-loop tests.

---
 rtl/kv_lookup_responder_if.sv | 27 ++
 rtl/kv_lookup_responder.sv | 202 ++++++++++++++++++++
 tb/tb_kv_lookup_responder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/kv_lookup_responder_if.sv
// kv_req_if: key-request bus between eth_encap (master) and a key-table responder (slave).
//   in_key    master->slave  request key
//   in_flag   master->slave  opcode (0001 lookup, 0010 insert, 0100 delete)
//   in_valid  master->slave  request valid
//   in_ready  slave->master  responder can accept a request
//   out_valid slave->master  one-cycle response strobe, no backpressure
//   out_flag  slave->master  result flag {illegal, written, collision, hit}
interface kv_req_if #(
    parameter int unsigned KEY_SIZE = 96
);
    logic [KEY_SIZE-1:0] in_key;
    logic [3:0]          in_flag;
    logic                in_valid;
    logic                in_ready;
    logic                out_valid;
    logic [3:0]          out_flag;

    modport master (
        output in_key, in_flag, in_valid,
        input  in_ready, out_valid, out_flag
    );

    modport slave (
        input  in_key, in_flag, in_valid,
        output in_ready, out_valid, out_flag
    );
endinterface

// File: rtl/kv_lookup_responder.sv
// kv_lookup_responder: responder for the eth_encap key-request bus. Keeps a direct-mapped key
// table (2^HASH_BITS entries of {valid, key}) indexed by an XOR fold of the key, and services
// lookup / insert / delete one request at a time (accept, read, compare/write, respond).
//
// Ports:
//   clk156    Ethernet core clock, the only clock
//   rst_n     synchronous active-low reset; starts a full table sweep
//   init_mem  table-clear request, acts on its rising edge
//   bus       kv_req_if slave modport (in_key/in_flag/in_valid/in_ready/out_valid/out_flag)
//   hit_cnt   (DB_STATS_EN only) saturating count of lookup hits
//   miss_cnt  (DB_STATS_EN only) saturating count of lookup misses
//
// Optional feature macro: DB_STATS_EN adds the hit_cnt/miss_cnt counters and ports.
module kv_lookup_responder #(
    parameter int unsigned KEY_SIZE  = 96,
    parameter int unsigned HASH_BITS = 10
) (
    input  logic        clk156,
    input  logic        rst_n,
    input  logic        init_mem,
    kv_req_if.slave     bus
`ifdef DB_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int unsigned Depth  = 2 ** HASH_BITS;
    localparam int unsigned Chunks = (KEY_SIZE + HASH_BITS - 1) / HASH_BITS;
    localparam int unsigned PadW   = Chunks * HASH_BITS;

    localparam logic [3:0] OpLookup = 4'b0001;
    localparam logic [3:0] OpInsert = 4'b0010;
    localparam logic [3:0] OpDelete = 4'b0100;

    typedef enum logic [2:0] {StClear, StIdle, StRd, StCmp, StResp} state_e;

    state_e                state_q, state_d;
    logic [HASH_BITS-1:0]  sweep_q, sweep_d;
    logic                  init_mem_q;
    logic                  pend_q, pend_d;
    logic [3:0]            flag_q, flag_d;
    logic                  out_valid_q, out_valid_d;

    logic [KEY_SIZE-1:0]   key_q;
    logic [3:0]            op_q;
    logic [HASH_BITS-1:0]  idx_q;

    // Table word: {valid, key}. No reset; the CLEAR sweep invalidates every entry.
    logic [KEY_SIZE:0]     mem [Depth];
    logic [KEY_SIZE:0]     rd_q;

    logic                  we;
    logic [HASH_BITS-1:0]  waddr;
    logic [KEY_SIZE:0]     wdata;

    logic                  init_rise;
    logic                  accept;
    logic [PadW-1:0]       key_pad;
    logic [HASH_BITS-1:0]  hash;
    logic                  hit;
    logic                  coll;

    assign init_rise    = init_mem & ~init_mem_q;
    // A fresh init_mem edge in IDLE blocks acceptance so the clear wins over a coincident request.
    assign bus.in_ready = (state_q == StIdle) & ~pend_q & ~init_rise;
    assign accept       = bus.in_valid & bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_flag  = flag_q;

    // XOR-fold of the key in HASH_BITS chunks from the LSB; top chunk zero-padded.
    always_comb begin
        key_pad                 = '0;
        key_pad[KEY_SIZE-1:0]   = bus.in_key;
        hash                    = '0;
        for (int i = 0; i < Chunks; i++) begin
            hash = hash ^ key_pad[i*HASH_BITS +: HASH_BITS];
        end
    end

    assign hit  = rd_q[KEY_SIZE] && (rd_q[KEY_SIZE-1:0] == key_q);
    assign coll = rd_q[KEY_SIZE] && !hit;

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        pend_d      = pend_q;
        flag_d      = flag_q;
        out_valid_d = 1'b0;
        we          = 1'b0;
        waddr       = sweep_q;
        wdata       = '0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRd;
                end else if (pend_q || init_rise) begin
                    state_d = StClear;
                    sweep_d = '0;
                    pend_d  = 1'b0;
                end
            end
            StRd: begin
                if (init_rise) pend_d = 1'b1;
                state_d = StCmp;
            end
            StCmp: begin
                if (init_rise) pend_d = 1'b1;
                state_d     = StResp;
                out_valid_d = 1'b1;
                waddr       = idx_q;
                case (op_q)
                    OpLookup: flag_d = {2'b00, coll, hit};
                    OpInsert: begin
                        flag_d = {2'b01, coll, hit};
                        we     = 1'b1;
                        wdata  = {1'b1, key_q};
                    end
                    OpDelete: begin
                        flag_d = {1'b0, hit, coll, hit};
                        we     = hit;
                        wdata  = {1'b0, key_q};
                    end
                    default:  flag_d = 4'b1000;
                endcase
            end
            StResp: begin
                if (init_rise) pend_d = 1'b1;
                state_d = StIdle;
            end
            StClear: begin
                // A new init_mem edge mid-sweep restarts from address 0.
                if (init_rise) begin
                    sweep_d = '0;
                end else begin
                    we = 1'b1;
                    if (sweep_q == '1) begin
                        state_d = StIdle;
                    end else begin
                        sweep_d = sweep_q + 1'b1;
                    end
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (!rst_n) begin
            state_q     <= StClear;
            sweep_q     <= '0;
            init_mem_q  <= 1'b0;
            pend_q      <= 1'b0;
            flag_q      <= 4'b0000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            init_mem_q  <= init_mem;
            pend_q      <= pend_d;
            flag_q      <= flag_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk156) begin
        if (accept) begin
            key_q <= bus.in_key;
            op_q  <= bus.in_flag;
            idx_q <= hash;
        end
    end

    // Single-port-write, synchronous-read table (BRAM-inferable).
    always_ff @(posedge clk156) begin
        if (we) mem[waddr] <= wdata;
        rd_q <= mem[idx_q];
    end

`ifdef DB_STATS_EN
    logic [31:0] hit_q, miss_q;
    logic        stat_lookup;
    logic        stat_clear;

    // Counted as the response is launched so the count is current while out_valid is high.
    assign stat_lookup = (state_q == StCmp) && (op_q == OpLookup);
    assign stat_clear  = (state_d == StClear);

    always_ff @(posedge clk156) begin
        if (!rst_n || stat_clear) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (stat_lookup) begin
            if (hit && hit_q != '1)   hit_q  <= hit_q + 32'd1;
            if (!hit && miss_q != '1) miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`endif
endmodule

// File: tb/tb_kv_lookup_responder.sv
// Self-checking bench for kv_lookup_responder: directed vector table, hand-written clear/reset
// corner sequences, and randomized requests against an associative-array table model.
module tb_kv_lookup_responder;
    localparam logic [3:0] OpLookup = 4'b0001;
    localparam logic [3:0] OpInsert = 4'b0010;
    localparam logic [3:0] OpDelete = 4'b0100;

    logic clk156 = 1'b0;
    logic rst_n = 1'b0;
    logic init_mem = 1'b0;
    int   checks = 0;
    int   failures = 0;

    kv_req_if #(.KEY_SIZE(96)) bus ();

`ifdef DB_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    kv_lookup_responder #(.KEY_SIZE(96), .HASH_BITS(10)) dut (
        .clk156   (clk156),
        .rst_n    (rst_n),
        .init_mem (init_mem),
        .bus      (bus)
`ifdef DB_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #3 clk156 = ~clk156;

    typedef struct {
        logic [3:0]  op;
        logic [95:0] key;
        logic [3:0]  exp;
    } vec_t;

    vec_t        vecs [17];
    logic [95:0] mkey [int];
    logic [95:0] pool [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int model_hash(input logic [95:0] k);
        int h = 0;
        for (int i = 0; i < 96; i += 10) h = h ^ int'((k >> i) & 96'h3ff);
        return h;
    endfunction

    // Called at a negedge: counts consecutive negedge samples with in_ready low (this one
    // included); n = -1 if in_ready never rises within the bound.
    task automatic wait_ready_count(input int bound, output int n, output logic ov);
        n  = 0;
        ov = 1'b0;
        while (bus.in_ready !== 1'b1 && n < bound) begin
            if (bus.out_valid === 1'b1) ov = 1'b1;
            n++;
            @(negedge clk156);
        end
        if (bus.in_ready !== 1'b1) n = -1;
    endtask

    // Issues one request and samples negedges j=1..6 after the accept edge (j=k is the value
    // presented at edge T+k). Optionally pulses init_mem starting at sample pulse_at.
    task automatic do_req(input logic [3:0] op, input logic [95:0] key, input int pulse_at,
                          output logic [3:0] flag, output int vpos, output int vcnt,
                          output logic [6:1] rdy);
        int w;
        flag = 'x;
        vpos = 0;
        vcnt = 0;
        rdy  = '0;
        w    = 0;
        while (bus.in_ready !== 1'b1 && w < 3000) begin
            @(negedge clk156);
            w++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=in_ready_low required=in_ready_high");
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_flag  = op;
        bus.in_key   = key;
        @(posedge clk156);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk156);
            rdy[j] = bus.in_ready;
            if (bus.out_valid === 1'b1) begin
                vcnt++;
                vpos = j;
                flag = bus.out_flag;
            end
            if (j == 1) begin
                // Junk on the bus while not valid must be ignored.
                bus.in_valid = 1'b0;
                bus.in_key   = {$urandom, $urandom, $urandom};
                bus.in_flag  = 4'($urandom);
            end
            init_mem = (j == pulse_at);
        end
    endtask

    initial begin
        logic [3:0]  f;
        logic [3:0]  e;
        logic [6:1]  rdy;
        logic [95:0] k;
        logic [3:0]  op;
        logic        ov, v, hit, coll;
        int          vp, vc, n, h, r;

        bus.in_valid = 1'b0;
        bus.in_key   = '0;
        bus.in_flag  = '0;

        vecs[0]  = '{op: OpInsert, key: 96'h1,   exp: 4'b0100};
        vecs[1]  = '{op: OpLookup, key: 96'h1,   exp: 4'b0001};
        vecs[2]  = '{op: OpLookup, key: 96'h400, exp: 4'b0010};
        vecs[3]  = '{op: OpInsert, key: 96'h400, exp: 4'b0110};
        vecs[4]  = '{op: OpLookup, key: 96'h1,   exp: 4'b0010};
        vecs[5]  = '{op: OpLookup, key: 96'h400, exp: 4'b0001};
        vecs[6]  = '{op: OpInsert, key: 96'h1,   exp: 4'b0110};
        vecs[7]  = '{op: OpDelete, key: 96'h1,   exp: 4'b0101};
        vecs[8]  = '{op: OpDelete, key: 96'h1,   exp: 4'b0000};
        vecs[9]  = '{op: OpLookup, key: 96'h1,   exp: 4'b0000};
        vecs[10] = '{op: OpInsert, key: 96'h1,   exp: 4'b0100};
        vecs[11] = '{op: 4'b0011,  key: 96'h1,   exp: 4'b1000};
        vecs[12] = '{op: OpLookup, key: 96'h1,   exp: 4'b0001};
        vecs[13] = '{op: OpDelete, key: 96'h400, exp: 4'b0010};
        vecs[14] = '{op: OpLookup, key: 96'h1,   exp: 4'b0001};
        vecs[15] = '{op: 4'b0000,  key: 96'h1,   exp: 4'b1000};
        vecs[16] = '{op: 4'b1000,  key: 96'h1,   exp: 4'b1000};

        // Reset state and post-reset sweep length.
        repeat (3) @(posedge clk156);
        @(negedge clk156);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_flag", 64'(bus.out_flag), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b1;
        wait_ready_count(3000, n, ov);
        check("reset_sweep_len", 64'(n), 64'd1024);
        check("reset_sweep_no_out_valid", 64'(ov), 64'd0);

        // Directed vectors: flag, strobe at T+3 only, in_ready low T+1..T+3 and high at T+4.
        for (int i = 0; i < 17; i++) begin
            do_req(vecs[i].op, vecs[i].key, 0, f, vp, vc, rdy);
            check($sformatf("vec%0d_flag", i), 64'(f), 64'(vecs[i].exp));
            check($sformatf("vec%0d_strobe_pos", i), 64'(vp), 64'd3);
            check($sformatf("vec%0d_strobe_cnt", i), 64'(vc), 64'd1);
            check($sformatf("vec%0d_ready_trace", i), 64'(rdy), 64'b111000);
        end

        // init_mem edge during RD of a hitting lookup: response still arrives, then one IDLE
        // cycle with the pending clear plus the 1024-cycle sweep keep in_ready low (1025).
        do_req(OpLookup, 96'h1, 1, f, vp, vc, rdy);
        check("init_inflight_flag", 64'(f), 64'b0001);
        check("init_inflight_pos", 64'(vp), 64'd3);
        check("init_inflight_trace", 64'(rdy), 64'b000000);
        wait_ready_count(3000, n, ov);
        check("init_inflight_low_len", 64'(n + 2), 64'd1025);
        check("init_inflight_no_extra_ov", 64'(ov), 64'd0);
        do_req(OpLookup, 96'h1, 0, f, vp, vc, rdy);
        check("after_clear_lookup", 64'(f), 64'b0000);

        // Request coincident with an init_mem edge in IDLE: not accepted, clear wins; init_mem
        // held high afterwards must not retrigger.
        bus.in_valid = 1'b1;
        bus.in_flag  = OpInsert;
        bus.in_key   = 96'h5;
        init_mem     = 1'b1;
        #1;
        check("coincide_ready_low", 64'(bus.in_ready), 64'd0);
        @(posedge clk156);
        @(negedge clk156);
        bus.in_valid = 1'b0;
        wait_ready_count(3000, n, ov);
        check("coincide_sweep_len", 64'(n), 64'd1024);
        check("coincide_no_out_valid", 64'(ov), 64'd0);
        init_mem = 1'b0;
        do_req(OpLookup, 96'h5, 0, f, vp, vc, rdy);
        check("coincide_not_inserted", 64'(f), 64'b0000);

        // Second edge 300 cycles into a sweep restarts it: 1024 more low cycles from there.
        init_mem = 1'b1;
        @(negedge clk156);
        init_mem = 1'b0;
        repeat (299) @(negedge clk156);
        init_mem = 1'b1;
        @(negedge clk156);
        init_mem = 1'b0;
        wait_ready_count(3000, n, ov);
        check("restart_sweep_len", 64'(n), 64'd1024);

`ifdef DB_STATS_EN
        do_req(OpInsert, 96'h7, 0, f, vp, vc, rdy);
        for (int i = 0; i < 3; i++) do_req(OpLookup, 96'h7, 0, f, vp, vc, rdy);
        for (int i = 0; i < 2; i++) do_req(OpLookup, 96'h9, 0, f, vp, vc, rdy);
        do_req(OpInsert, 96'h8, 0, f, vp, vc, rdy);
        check("stats_hit_cnt", 64'(hit_cnt), 64'd3);
        check("stats_miss_cnt", 64'(miss_cnt), 64'd2);
        init_mem = 1'b1;
        @(negedge clk156);
        init_mem = 1'b0;
        wait_ready_count(3000, n, ov);
        check("stats_hit_cleared", 64'(hit_cnt), 64'd0);
        check("stats_miss_cleared", 64'(miss_cnt), 64'd0);
`endif

        // Randomized requests over a small key pool with deliberate hash collisions.
        pool[0] = 96'h1;
        pool[1] = 96'h400;
        pool[2] = {$urandom, $urandom, $urandom};
        pool[3] = pool[2] ^ 96'h401;
        pool[4] = {$urandom, $urandom, $urandom};
        pool[5] = pool[4] ^ (96'h1 << 90) ^ 96'h1;
        pool[6] = 96'h2;
        pool[7] = 96'h800;
        for (int i = 0; i < 200; i++) begin
            k = pool[$urandom_range(0, 7)];
            r = int'($urandom_range(0, 9));
            if (r < 4)      op = OpLookup;
            else if (r < 7) op = OpInsert;
            else if (r < 9) op = OpDelete;
            else begin
                r  = int'($urandom_range(0, 3));
                op = (r == 0) ? 4'b0000 : (r == 1) ? 4'b0011 : (r == 2) ? 4'b1000 : 4'b1111;
            end
            h    = model_hash(k);
            v    = mkey.exists(h);
            hit  = v && (mkey[h] == k);
            coll = v && !hit;
            case (op)
                OpLookup: e = {2'b00, coll, hit};
                OpInsert: begin
                    e       = {2'b01, coll, hit};
                    mkey[h] = k;
                end
                OpDelete: begin
                    e = {1'b0, hit, coll, hit};
                    if (hit) mkey.delete(h);
                end
                default:  e = 4'b1000;
            endcase
            do_req(op, k, 0, f, vp, vc, rdy);
            check($sformatf("rand%0d_op%0h_flag", i, op), 64'(f), 64'(e));
            check($sformatf("rand%0d_strobe_pos", i), 64'(vp), 64'd3);
        end

        // Reset one cycle into a request: no response, fresh full sweep, table empty after.
        do_req(OpInsert, 96'h1, 0, f, vp, vc, rdy);
        bus.in_valid = 1'b1;
        bus.in_flag  = OpLookup;
        bus.in_key   = 96'h1;
        @(posedge clk156);
        @(negedge clk156);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk156);
        rst_n = 1'b1;
        wait_ready_count(3000, n, ov);
        check("midreq_reset_sweep_len", 64'(n), 64'd1024);
        check("midreq_reset_no_out_valid", 64'(ov), 64'd0);
        do_req(OpLookup, 96'h1, 0, f, vp, vc, rdy);
        check("midreq_reset_table_cleared", 64'(f), 64'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
